// File: rtl/uart_word_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_word_rx
// Brief    : 8N1 UART receiver that packs WORD_BYTES bytes (little-endian)
//            into one BIT_DEPTH-bit word and presents it with a one-cycle
//            write strobe. Flags framing errors and inter-byte timeouts and
//            discards any partial word when either occurs.
// Revision : 1.0 - initial release
// ============================================================================
module uart_word_rx #(
    parameter int CLK_FREQ_HZ  = 100000000,
    parameter int BAUD         = 115200,
    parameter int BIT_DEPTH    = 32,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                 clk,
    input  logic                 rst,            // asynchronous, active-low
    input  logic                 rx,
    output logic [BIT_DEPTH-1:0] value_to_write,
    output logic                 enable_write,
    output logic                 frame_error,
    output logic                 word_dropped,
    output logic                 busy
);

    localparam int c_CPB        = CLK_FREQ_HZ / BAUD;
    localparam int c_HALF       = c_CPB / 2;
    localparam int c_WORD_BYTES = BIT_DEPTH / 8;
    localparam int c_TIMEOUT    = TIMEOUT_BITS * c_CPB;
    localparam int c_BAUD_W     = $clog2(c_CPB);
    localparam int c_TMO_W      = $clog2(c_TIMEOUT);
    localparam int c_IDX_W      = (c_WORD_BYTES > 1) ? $clog2(c_WORD_BYTES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_rx_meta;
    logic                   r_rx_sync;
    logic                   r_rx_prev;
    logic [c_BAUD_W-1:0]    r_baud_cnt;
    logic [2:0]             r_bit_cnt;
    logic [7:0]             r_shift;
    logic [c_IDX_W-1:0]     r_byte_idx;
    logic [c_TMO_W-1:0]     r_tmo_cnt;
    logic [BIT_DEPTH-1:0]   r_word;
    logic [BIT_DEPTH-1:0]   r_value;
    logic                   r_enable_write;
    logic                   r_frame_error;
    logic                   r_word_dropped;

    logic                   w_fall;
    logic                   w_half_done;
    logic                   w_full_done;
    logic                   w_baud_clr;
    logic                   w_start_det;
    logic                   w_enter_data;
    logic                   w_sample_bit;
    logic                   w_byte_ok;
    logic                   w_byte_bad;
    logic                   w_timeout;
    logic                   w_last_byte;
    logic [BIT_DEPTH-1:0]   w_word_merged;

    assign w_fall      = r_rx_prev & ~r_rx_sync;
    assign w_half_done = (r_baud_cnt == c_BAUD_W'(c_HALF - 1));
    assign w_full_done = (r_baud_cnt == c_BAUD_W'(c_CPB - 1));
    assign w_last_byte = (r_byte_idx == c_IDX_W'(c_WORD_BYTES - 1));
    // Timeout only accumulates while a partial word is parked in IDLE.
    assign w_timeout   = (r_state == S_IDLE) && (r_byte_idx != '0) &&
                         (r_tmo_cnt == c_TMO_W'(c_TIMEOUT - 1));

    // Two-flop synchroniser plus one history flop for falling-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and per-cycle datapath strobes.
    always_comb begin
        w_state_next = r_state;
        w_baud_clr   = 1'b0;
        w_start_det  = 1'b0;
        w_enter_data = 1'b0;
        w_sample_bit = 1'b0;
        w_byte_ok    = 1'b0;
        w_byte_bad   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_state_next = S_START;
                    w_baud_clr   = 1'b1;
                    w_start_det  = 1'b1;
                end
            end
            S_START: begin
                if (w_half_done) begin
                    w_baud_clr = 1'b1;
                    if (!r_rx_sync) begin
                        w_state_next = S_DATA;
                        w_enter_data = 1'b1;
                    end else begin
                        // Start bit vanished before mid-bit: treat as a glitch.
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (w_full_done) begin
                    w_baud_clr   = 1'b1;
                    w_sample_bit = 1'b1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (w_full_done) begin
                    w_baud_clr   = 1'b1;
                    w_state_next = S_IDLE;
                    if (r_rx_sync) begin
                        w_byte_ok  = 1'b1;
                    end else begin
                        w_byte_bad = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Baud counter: parked at zero in IDLE, restarted at every bit boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_baud_cnt <= '0;
        end else if (w_baud_clr || (r_state == S_IDLE)) begin
            r_baud_cnt <= '0;
        end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
        end
    end

    // Bit counter and LSB-first shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else if (w_enter_data) begin
            r_bit_cnt <= '0;
        end else if (w_sample_bit) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            r_shift   <= {r_rx_sync, r_shift[7:1]};
        end
    end

    // Current partial word with the just-received byte dropped into its slot.
    always_comb begin
        w_word_merged = r_word;
        w_word_merged[{r_byte_idx, 3'b000} +: 8] = r_shift;
    end

    // Inter-byte timeout counter; a start landing on the expiry cycle still
    // proceeds, and sees byte_index already cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmo_cnt <= '0;
        end else if (w_timeout || w_start_det || (r_state != S_IDLE) ||
                     (r_byte_idx == '0)) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // Word assembly, completion strobe and error pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_byte_idx     <= '0;
            r_word         <= '0;
            r_value        <= '0;
            r_enable_write <= 1'b0;
            r_frame_error  <= 1'b0;
            r_word_dropped <= 1'b0;
        end else begin
            r_enable_write <= 1'b0;
            r_frame_error  <= 1'b0;
            r_word_dropped <= 1'b0;
            if (w_timeout) begin
                r_word_dropped <= 1'b1;
                r_byte_idx     <= '0;
            end
            if (w_byte_ok) begin
                r_word <= w_word_merged;
                if (w_last_byte) begin
                    r_value        <= w_word_merged;
                    r_enable_write <= 1'b1;
                    r_byte_idx     <= '0;
                end else begin
                    r_byte_idx     <= r_byte_idx + 1'b1;
                end
            end else if (w_byte_bad) begin
                r_frame_error  <= 1'b1;
                r_word_dropped <= (r_byte_idx != '0);
                r_byte_idx     <= '0;
            end
        end
    end

    assign value_to_write = r_value;
    assign enable_write   = r_enable_write;
    assign frame_error    = r_frame_error;
    assign word_dropped   = r_word_dropped;
    assign busy           = (r_state != S_IDLE) || (r_byte_idx != '0);

endmodule
`default_nettype wire

// File: tb/tb_uart_word_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_word_rx
// Brief    : Directed self-checking bench for uart_word_rx (CPB = 16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_word_rx;

    localparam int CLK_FREQ_HZ  = 1600;
    localparam int BAUD         = 100;
    localparam int BIT_DEPTH    = 32;
    localparam int TIMEOUT_BITS = 20;
    localparam int CPB          = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 rx  = 1'b1;
    logic [BIT_DEPTH-1:0] value_to_write;
    logic                 enable_write;
    logic                 frame_error;
    logic                 word_dropped;
    logic                 busy;

    int n_assert = 0;
    int n_fail   = 0;

    // Pulse monitor state
    int   cyc = 0, n_ew = 0, n_fe = 0, n_wd = 0, n_fe_wd = 0, n_viol = 0;
    int   t_ew_prev = 0, t_ew_last = 0;
    logic p_ew = 1'b0, p_fe = 1'b0, p_wd = 1'b0;
    logic [31:0] caps [0:63];

    // Snapshots
    int b_ew, b_fe, b_wd, b_fewd;

    uart_word_rx #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .BAUD        (BAUD),
        .BIT_DEPTH   (BIT_DEPTH),
        .TIMEOUT_BITS(TIMEOUT_BITS)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .value_to_write(value_to_write),
        .enable_write  (enable_write),
        .frame_error   (frame_error),
        .word_dropped  (word_dropped),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Count pulses, capture completed words and flag protocol violations.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (enable_write) begin
            if (n_ew < 64) caps[n_ew] = value_to_write;
            n_ew      = n_ew + 1;
            t_ew_prev = t_ew_last;
            t_ew_last = cyc;
        end
        if (frame_error)                 n_fe    = n_fe + 1;
        if (word_dropped)                n_wd    = n_wd + 1;
        if (frame_error && word_dropped) n_fe_wd = n_fe_wd + 1;
        if ((enable_write && p_ew) || (frame_error && p_fe) ||
            (word_dropped && p_wd) || (enable_write && word_dropped))
            n_viol = n_viol + 1;
        p_ew = enable_write;
        p_fe = frame_error;
        p_wd = word_dropped;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert = n_assert + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Hold one serial bit for CPB clocks.
    task automatic send_bit(input logic v);
        @(negedge clk);
        rx = v;
        repeat (CPB - 1) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_bit);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic snap();
        b_ew   = n_ew;
        b_fe   = n_fe;
        b_wd   = n_wd;
        b_fewd = n_fe_wd;
    endtask

    initial begin
        // Reset state
        wait_clks(3);
        check("rst_value", value_to_write, 64'h0);
        check("rst_ew",    enable_write,   64'h0);
        check("rst_fe",    frame_error,    64'h0);
        check("rst_wd",    word_dropped,   64'h0);
        check("rst_busy",  busy,           64'h0);
        rst = 1'b1;
        wait_clks(5);

        // Single word
        snap();
        send_word(32'h12345678);
        wait_clks(20);
        check("w1_count", n_ew - b_ew, 64'd1);
        check("w1_value", value_to_write, 64'h12345678);
        check("w1_fe",    n_fe - b_fe, 64'd0);
        check("w1_busy",  busy, 64'h0);

        // Two words back-to-back: 4 frames x 10 bit-times x 16 clk = 640 clk apart
        snap();
        send_word(32'h12345678);
        send_word(32'hDEADBEEF);
        wait_clks(20);
        check("w2_count",   n_ew - b_ew, 64'd2);
        check("w2_first",   caps[b_ew],     64'h12345678);
        check("w2_second",  caps[b_ew + 1], 64'hDEADBEEF);
        check("w2_spacing", t_ew_last - t_ew_prev, 64'd640);

        // Framing error on the second byte of a word
        snap();
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b0);
        send_bit(1'b1);
        wait_clks(4);
        check("fe_count",   n_fe - b_fe,      64'd1);
        check("fe_wd",      n_wd - b_wd,      64'd1);
        check("fe_samecyc", n_fe_wd - b_fewd, 64'd1);
        check("fe_no_ew",   n_ew - b_ew,      64'd0);
        check("fe_busy",    busy,             64'h0);
        snap();
        send_word(32'h04030201);
        wait_clks(20);
        check("fe_rec_count", n_ew - b_ew, 64'd1);
        check("fe_rec_value", value_to_write, 64'h04030201);

        // 4-clk glitch from idle
        snap();
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        #1;
        check("gl_busy_mid", busy, 64'h1);
        wait_clks(24);
        check("gl_busy_end", busy, 64'h0);
        check("gl_ew", n_ew - b_ew, 64'd0);
        check("gl_fe", n_fe - b_fe, 64'd0);
        check("gl_wd", n_wd - b_wd, 64'd0);

        // Inter-byte timeout (expiry ~315 clk after the second stop bit ends)
        snap();
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        wait_clks(300);
        check("to_not_yet", n_wd - b_wd, 64'd0);
        check("to_busy_pre", busy, 64'h1);
        wait_clks(36);
        check("to_wd",   n_wd - b_wd, 64'd1);
        check("to_busy", busy, 64'h0);
        check("to_no_ew", n_ew - b_ew, 64'd0);
        snap();
        send_word(32'h04030201);
        wait_clks(20);
        check("to_rec_count", n_ew - b_ew, 64'd1);
        check("to_rec_value", value_to_write, 64'h04030201);

        // Reset during bit 4 of the second byte (0xF0: bits 4..7 and stop are high)
        snap();
        send_byte(8'h3C, 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("mr_busy_pre", busy, 64'h1);
        rst = 1'b0;
        #1;
        check("mr_value", value_to_write, 64'h0);
        check("mr_busy",  busy,           64'h0);
        check("mr_ew",    enable_write,   64'h0);
        check("mr_fe",    frame_error,    64'h0);
        check("mr_wd",    word_dropped,   64'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        wait_clks(CPB * 6);
        check("mr_idle_busy", busy, 64'h0);
        check("mr_no_ew", n_ew - b_ew, 64'd0);
        snap();
        send_word(32'hD4C3B2A1);
        wait_clks(20);
        check("mr_rec_count", n_ew - b_ew, 64'd1);
        check("mr_rec_value", value_to_write, 64'hD4C3B2A1);

        // Pulse width / exclusivity over the whole run
        check("pulse_rules", n_viol, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
